// File: rtl/bp_update_queue_pkg.sv
// Shared frontend types for the branch-prediction update queue: metadata and
// update beats, per-entry state, and the tag-width and age helpers.
package bp_update_queue_pkg;

    typedef struct packed {
        int unsigned VLEN;
    } bpq_cfg_t;

    localparam int unsigned BPQ_VLEN = 32'd32;
    localparam bpq_cfg_t bpq_cfg_empty = '{VLEN: BPQ_VLEN};

    typedef struct packed {
        logic lbp_valid;
        logic lbp_taken;
        logic gbp_valid;
        logic gbp_taken;
    } bpq_metadata_t;

    typedef struct packed {
        logic                valid;
        logic [BPQ_VLEN-1:0] pc;
        logic                taken;
        bpq_metadata_t       metadata;
    } bpq_bht_update_t;

    typedef enum logic [1:0] {
        BPQ_FREE     = 2'd0,
        BPQ_PENDING  = 2'd1,
        BPQ_RESOLVED = 2'd2
    } bpq_state_e;

    typedef struct packed {
        logic [BPQ_VLEN-1:0] pc;
        bpq_metadata_t       metadata;
        logic                taken;
        bpq_state_e          state;
    } bpq_entry_t;

    // One extra tag bit beyond the index distinguishes full from empty.
    function automatic int unsigned bpq_tag_w(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

    // True when tag a is younger than tag b, measured as distance from head.
    function automatic logic bpq_is_younger(input logic [31:0]  head,
                                            input logic [31:0]  a,
                                            input logic [31:0]  b,
                                            input int unsigned  tag_w);
        logic [31:0] mask;
        mask = (32'd1 << tag_w) - 32'd1;
        return ((a - head) & mask) > ((b - head) & mask);
    endfunction

endpackage

// File: rtl/bp_update_queue.sv
// In-order queue of branch prediction metadata: allocated at fetch, resolved
// out of order by execute, drained in program order as BHT training beats.
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter bpq_cfg_t    CVA6Cfg       = bpq_cfg_empty,
    parameter type         bp_metadata_t = bpq_metadata_t,
    parameter type         bht_update_t  = bpq_bht_update_t,
    parameter int unsigned DEPTH         = 32'd8,
    localparam int unsigned VLEN         = CVA6Cfg.VLEN,
    localparam int unsigned TAG_W        = bpq_tag_w(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_bp_i,
    input  logic                             debug_mode_i,
    input  logic                             alloc_valid_i,
    output logic                             alloc_ready_o,
    input  logic [VLEN-1:0]                  alloc_pc_i,
    input  logic [$bits(bp_metadata_t)-1:0]  alloc_metadata_i,
    output logic [TAG_W-1:0]                 alloc_tag_o,
    input  logic                             resolve_valid_i,
    input  logic [TAG_W-1:0]                 resolve_tag_i,
    input  logic                             resolve_taken_i,
    input  logic                             squash_valid_i,
    input  logic [TAG_W-1:0]                 squash_tag_i,
    output logic [$bits(bht_update_t)-1:0]   bht_update_o
);

    localparam int unsigned       IDX_W   = TAG_W - 32'd1;
    localparam logic [TAG_W-1:0]  TAG_ONE = TAG_W'(32'd1);
    localparam logic [TAG_W-1:0]  DEPTH_T = TAG_W'(DEPTH);

    bpq_entry_t        entry_q [DEPTH];
    bpq_entry_t        entry_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    bht_update_t       bht_q, bht_d;

    logic [TAG_W-1:0]  count_s;
    logic              full_s;
    logic              alloc_fire_s;
    logic [TAG_W-1:0]  sq_dist_s;
    logic              squash_hit_s;
    logic              res_kill_s;
    logic              drain_s;
    logic [IDX_W-1:0]  head_idx_s;
    logic [IDX_W-1:0]  tail_idx_s;
    logic [IDX_W-1:0]  res_idx_s;

    assign count_s       = tail_q - head_q;
    assign full_s        = (count_s == DEPTH_T);
    assign alloc_ready_o = !full_s && !squash_valid_i && !flush_bp_i && !rst_i;
    assign alloc_tag_o   = tail_q;
    assign alloc_fire_s  = alloc_valid_i && alloc_ready_o;
    assign head_idx_s    = head_q[IDX_W-1:0];
    assign tail_idx_s    = tail_q[IDX_W-1:0];
    assign res_idx_s     = resolve_tag_i[IDX_W-1:0];
    assign bht_update_o  = bht_q;

    // A squash tag outside [head, tail) lies beyond the live window and is ignored.
    assign sq_dist_s     = squash_tag_i - head_q;
    assign squash_hit_s  = squash_valid_i && (sq_dist_s < count_s);
    assign res_kill_s    = squash_hit_s &&
                           bpq_is_younger(32'(head_q), 32'(resolve_tag_i), 32'(squash_tag_i), TAG_W);
    assign drain_s       = (entry_q[head_idx_s].state == BPQ_RESOLVED);

    // Next-state for entries, pointers and the training beat, flush first.
    always_comb begin
        logic [TAG_W-1:0] tag_v;
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        bht_d   = '0;
        tag_v   = '0;
        if (flush_bp_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].state = BPQ_FREE;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            if (drain_s) begin
                bht_d.valid    = !debug_mode_i;
                bht_d.pc       = entry_q[head_idx_s].pc;
                bht_d.taken    = entry_q[head_idx_s].taken;
                bht_d.metadata = entry_q[head_idx_s].metadata;
                entry_d[head_idx_s].state = BPQ_FREE;
                head_d = head_q + TAG_ONE;
            end else begin
                bht_d = '0;
            end
            if (resolve_valid_i && !res_kill_s &&
                (entry_q[res_idx_s].state == BPQ_PENDING)) begin
                entry_d[res_idx_s].taken = resolve_taken_i;
                entry_d[res_idx_s].state = BPQ_RESOLVED;
            end else begin
                entry_d[res_idx_s] = entry_d[res_idx_s];
            end
            if (alloc_fire_s) begin
                entry_d[tail_idx_s].pc       = alloc_pc_i;
                entry_d[tail_idx_s].metadata = bpq_metadata_t'(alloc_metadata_i);
                entry_d[tail_idx_s].taken    = 1'b0;
                entry_d[tail_idx_s].state    = BPQ_PENDING;
                tail_d = tail_q + TAG_ONE;
            end else begin
                tail_d = tail_d;
            end
            if (squash_hit_s) begin
                // Rebuild each slot's tag from its distance to head before the age compare.
                for (int i = 0; i < DEPTH; i++) begin
                    tag_v = head_q + {1'b0, IDX_W'(i) - head_idx_s};
                    if (bpq_is_younger(32'(head_q), 32'(tag_v), 32'(squash_tag_i), TAG_W)) begin
                        entry_d[i].state = BPQ_FREE;
                    end else begin
                        entry_d[i].state = entry_d[i].state;
                    end
                end
                tail_d = squash_tag_i + TAG_ONE;
            end else begin
                tail_d = tail_d;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            bht_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            bht_q  <= bht_d;
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Randomized and directed bench for bp_update_queue against a queue-based
// program-order model of the in-flight branches.
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    localparam int D     = 8;
    localparam int TAG_W = 4;
    localparam int M     = 2 * D - 1;

    logic                 clk = 1'b0;
    logic                 rst_i, flush_bp_i, debug_mode_i;
    logic                 alloc_valid_i, alloc_ready_o;
    logic [31:0]          alloc_pc_i;
    logic [3:0]           alloc_metadata_i;
    logic [TAG_W-1:0]     alloc_tag_o;
    logic                 resolve_valid_i, resolve_taken_i;
    logic [TAG_W-1:0]     resolve_tag_i;
    logic                 squash_valid_i;
    logic [TAG_W-1:0]     squash_tag_i;
    logic [37:0]          bht_update_o;

    bp_update_queue #(.DEPTH(D)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_bp_i       (flush_bp_i),
        .debug_mode_i     (debug_mode_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_ready_o    (alloc_ready_o),
        .alloc_pc_i       (alloc_pc_i),
        .alloc_metadata_i (alloc_metadata_i),
        .alloc_tag_o      (alloc_tag_o),
        .resolve_valid_i  (resolve_valid_i),
        .resolve_tag_i    (resolve_tag_i),
        .resolve_taken_i  (resolve_taken_i),
        .squash_valid_i   (squash_valid_i),
        .squash_tag_i     (squash_tag_i),
        .bht_update_o     (bht_update_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [3:0]  meta;
        bit          res;
        bit          tk;
    } ment_t;

    ment_t q[$];
    int    m_head = 0;
    int    m_tail = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    bit    dbg_v = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        rst_i = 1'b0; flush_bp_i = 1'b0; debug_mode_i = dbg_v;
        alloc_valid_i = 1'b0; alloc_pc_i = 32'd0; alloc_metadata_i = 4'd0;
        resolve_valid_i = 1'b0; resolve_tag_i = 4'd0; resolve_taken_i = 1'b0;
        squash_valid_i = 1'b0; squash_tag_i = 4'd0;
    endtask

    // One clock: check combinational outputs, advance the model, check the beat.
    task automatic tick();
        bit              exp_ready, fire, drained, sq_hit, kill;
        int              cnt, sqd, rt, st;
        bpq_bht_update_t e;
        #1;
        exp_ready = (q.size() < D) && !squash_valid_i && !flush_bp_i && !rst_i;
        check_eq("alloc_ready", 64'(alloc_ready_o), 64'(exp_ready));
        if (!rst_i) check_eq("alloc_tag", 64'(alloc_tag_o), 64'(m_tail));
        fire = alloc_valid_i && exp_ready;
        rt = int'(resolve_tag_i);
        st = int'(squash_tag_i);
        @(posedge clk);
        e = '0;
        if (rst_i || flush_bp_i) begin
            q.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            drained = 1'b0;
            if (q.size() > 0 && q[0].res) begin
                e.valid = !debug_mode_i;
                e.pc = q[0].pc;
                e.taken = q[0].tk;
                e.metadata = q[0].meta;
                drained = 1'b1;
            end
            cnt = q.size();
            sqd = (st - m_head) & M;
            sq_hit = squash_valid_i && (sqd < cnt);
            if (resolve_valid_i) begin
                kill = sq_hit && (((rt - m_head) & M) > sqd);
                if (!kill) begin
                    foreach (q[i]) begin
                        if ((q[i].tag % D) == (rt % D) && !q[i].res) begin
                            q[i].res = 1'b1;
                            q[i].tk  = resolve_taken_i;
                        end
                    end
                end
            end
            if (sq_hit) begin
                while (q.size() > sqd + 1) void'(q.pop_back());
                m_tail = (st + 1) & M;
            end else if (fire) begin
                q.push_back('{m_tail, alloc_pc_i, alloc_metadata_i, 1'b0, 1'b0});
                m_tail = (m_tail + 1) & M;
            end
            if (drained) begin
                void'(q.pop_front());
                m_head = (m_head + 1) & M;
            end
        end
        #1;
        check_eq("bht_update", 64'(bht_update_o), 64'(e));
        @(negedge clk);
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [3:0] md);
        idle_in(); alloc_valid_i = 1'b1; alloc_pc_i = pc; alloc_metadata_i = md; tick();
    endtask

    task automatic do_resolve(input logic [3:0] t, input bit tk);
        idle_in(); resolve_valid_i = 1'b1; resolve_tag_i = t; resolve_taken_i = tk; tick();
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in(); tick();
        end
    endtask

    task automatic do_flush();
        idle_in(); flush_bp_i = 1'b1; tick();
    endtask

    initial begin
        idle_in();
        rst_i = 1'b1; tick();
        rst_i = 1'b1; tick();

        // Out-of-order resolve, in-order drain
        do_alloc(32'h80, 4'b1010);
        do_alloc(32'h84, 4'b0111);
        do_resolve(4'd1, 1'b1);
        do_resolve(4'd0, 1'b0);
        do_idle(3);

        // Fill, drain one, ninth alloc wraps
        do_flush();
        for (int i = 0; i < D; i++) do_alloc(32'h100 + 32'(4 * i), 4'(i));
        do_alloc(32'h200, 4'hF);
        do_resolve(4'd0, 1'b1);
        do_idle(1);
        do_alloc(32'h204, 4'h3);
        do_flush();

        // Squash tag 2, then stale and live resolves
        for (int i = 0; i < 5; i++) do_alloc(32'h300 + 32'(4 * i), 4'(i + 3));
        idle_in(); squash_valid_i = 1'b1; squash_tag_i = 4'd2; tick();
        do_resolve(4'd4, 1'b1);
        for (int i = 0; i < 3; i++) do_resolve(4'(i), i[0]);
        do_idle(4);
        do_flush();

        // Debug mode drains silently
        for (int i = 0; i < 3; i++) do_alloc(32'h400 + 32'(4 * i), 4'(i + 9));
        for (int i = 0; i < 3; i++) do_resolve(4'(i), 1'b1);
        dbg_v = 1'b1;
        do_idle(4);
        dbg_v = 1'b0;
        do_idle(2);
        do_flush();

        // Flush beats a resolved head
        do_alloc(32'h500, 4'h5);
        do_alloc(32'h504, 4'h6);
        do_resolve(4'd0, 1'b1);
        idle_in(); flush_bp_i = 1'b1; resolve_valid_i = 1'b1; resolve_tag_i = 4'd0; tick();
        do_idle(2);

        // Squash 3 with resolve 5 in the same cycle
        for (int i = 0; i < 7; i++) do_alloc(32'h600 + 32'(4 * i), 4'(i));
        idle_in(); squash_valid_i = 1'b1; squash_tag_i = 4'd3;
        resolve_valid_i = 1'b1; resolve_tag_i = 4'd5; resolve_taken_i = 1'b1; tick();
        do_resolve(4'd3, 1'b1);
        for (int i = 0; i < 3; i++) do_resolve(4'(i), 1'b0);
        do_idle(5);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            int j;
            idle_in();
            if ($urandom_range(0, 99) < 3) dbg_v = !dbg_v;
            debug_mode_i = dbg_v;
            alloc_valid_i = ($urandom_range(0, 99) < 50);
            alloc_pc_i = {$urandom_range(0, 32'hFFFF), 2'b00};
            alloc_metadata_i = 4'($urandom_range(0, 15));
            if (q.size() > 0 && $urandom_range(0, 99) < 50) begin
                j = $urandom_range(0, q.size() - 1);
                resolve_valid_i = 1'b1; resolve_tag_i = 4'(q[j].tag);
            end else if ($urandom_range(0, 99) < 5) begin
                resolve_valid_i = 1'b1; resolve_tag_i = 4'($urandom_range(0, 15));
            end
            resolve_taken_i = 1'($urandom_range(0, 1));
            if (q.size() > 0 && $urandom_range(0, 99) < 4) begin
                j = $urandom_range(0, q.size() - 1);
                squash_valid_i = 1'b1; squash_tag_i = 4'(q[j].tag);
            end else if ($urandom_range(0, 99) < 1) begin
                squash_valid_i = 1'b1; squash_tag_i = 4'($urandom_range(0, 15));
            end
            flush_bp_i = ($urandom_range(0, 199) == 0);
            rst_i = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
